// File: rtl/operand_mux_nto1.sv
// N-channel registered operand multiplexer feeding the multiplier core.
// Explicit-select or round-robin grant, one output register with valid/ready.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   EMPTY | output register holds no unconsumed word (Out_Valid = 0)
//   FULL  | output register holds a word awaiting Out_Ready (Out_Valid = 1)
module operand_mux_nto1 #(
  parameter int WORD_LENGTH = 4,
  parameter int WORD        = WORD_LENGTH * 2,
  parameter int CHANNELS    = 4,
  parameter int SEL_WIDTH   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       Mode,
  input  logic [SEL_WIDTH-1:0]       Selector,
  input  logic [CHANNELS*WORD-1:0]   Data_In,
  input  logic [CHANNELS-1:0]        In_Valid,
  output logic [CHANNELS-1:0]        In_Ready,
  output logic [WORD-1:0]            Mux_Output,
  output logic                       Out_Valid,
  input  logic                       Out_Ready,
  output logic [SEL_WIDTH-1:0]       Out_Channel
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [SEL_WIDTH-1:0]  last_grant_q;
  logic                  free;
  logic                  grant_valid;
  logic [SEL_WIDTH-1:0]  grant_idx;
  logic                  load;
  logic [WORD-1:0]       sel_word;

  assign Out_Valid = (state_q == FULL);
  assign free      = (state_q == EMPTY) || Out_Ready;

  // Grant search; round-robin scans channels above last_grant first, then wraps.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (!Mode) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (!grant_valid && Selector == SEL_WIDTH'(c) && In_Valid[c]) begin
          grant_valid = 1'b1;
          grant_idx   = SEL_WIDTH'(c);
        end
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (!grant_valid && c > int'(last_grant_q) && In_Valid[c]) begin
          grant_valid = 1'b1;
          grant_idx   = SEL_WIDTH'(c);
        end
      end
      for (int c = 0; c < CHANNELS; c++) begin
        if (!grant_valid && c <= int'(last_grant_q) && In_Valid[c]) begin
          grant_valid = 1'b1;
          grant_idx   = SEL_WIDTH'(c);
        end
      end
    end
  end

  assign load = free && grant_valid && !reset;

  always_comb begin
    In_Ready = '0;
    sel_word = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (grant_idx == SEL_WIDTH'(c)) begin
        In_Ready[c] = load;
        sel_word    = Data_In[c*WORD +: WORD];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (load) state_d = FULL;
      FULL: begin
        if (load)           state_d = FULL;
        else if (Out_Ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= EMPTY;
      Mux_Output   <= '0;
      Out_Channel  <= '0;
      // Pointer parked on the last channel so channel 0 wins first.
      last_grant_q <= SEL_WIDTH'(CHANNELS - 1);
    end else begin
      state_q <= state_d;
      if (load) begin
        Mux_Output   <= sel_word;
        Out_Channel  <= grant_idx;
        last_grant_q <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_operand_mux_nto1.sv
// Directed testbench for operand_mux_nto1 (4 channels, 8-bit words, 3-bit selector
// so that out-of-range selector values can be driven).
module tb_operand_mux_nto1;

  localparam int CH = 4;
  localparam int W  = 8;
  localparam int SW = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            Mode;
  logic [SW-1:0]   Selector;
  logic [CH*W-1:0] Data_In;
  logic [CH-1:0]   In_Valid;
  logic [CH-1:0]   In_Ready;
  logic [W-1:0]    Mux_Output;
  logic            Out_Valid;
  logic            Out_Ready;
  logic [SW-1:0]   Out_Channel;

  int passed = 0;
  int total  = 0;

  operand_mux_nto1 #(
    .WORD_LENGTH(4), .WORD(W), .CHANNELS(CH), .SEL_WIDTH(SW)
  ) dut (
    .clk(clk), .reset(reset), .Mode(Mode), .Selector(Selector),
    .Data_In(Data_In), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Mux_Output(Mux_Output), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Out_Channel(Out_Channel)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int c, input logic [W-1:0] w);
    Data_In[c*W +: W] = w;
  endtask

  task automatic do_reset();
    reset = 1'b1; Out_Ready = 1'b0; In_Valid = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; Mode = 1'b1; Selector = '0; In_Valid = 4'b1111; Out_Ready = 1'b0;
    set_word(0, 8'h20); set_word(1, 8'h21); set_word(2, 8'h22); set_word(3, 8'h23);
    step();
    step();
    total++; if (Mux_Output !== 8'h00) $display("FAIL reset_mux: got %h expected 00", Mux_Output); else passed++;
    total++; if (Out_Valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", Out_Valid); else passed++;
    total++; if (Out_Channel !== 3'd0) $display("FAIL reset_chan: got %0d expected 0", Out_Channel); else passed++;
    total++; if (In_Ready !== 4'b0000) $display("FAIL reset_in_ready: got %b expected 0000", In_Ready); else passed++;
    reset = 1'b0;
    #1;
    total++; if (In_Ready !== 4'b0001) $display("FAIL reset_first_grant: got %b expected 0001", In_Ready); else passed++;
    Out_Ready = 1'b1;
    step();
    total++; if (Out_Channel !== 3'd0 || Mux_Output !== 8'h20 || Out_Valid !== 1'b1)
      $display("FAIL reset_first_word: got ch %0d data %h v %b expected ch 0 data 20 v 1", Out_Channel, Mux_Output, Out_Valid);
    else passed++;
  endtask

  task automatic test_mode0();
    do_reset();
    Mode = 1'b0; Selector = 3'd2; set_word(2, 8'hA5); In_Valid = 4'b0100; Out_Ready = 1'b1;
    #1;
    total++; if (In_Ready !== 4'b0100) $display("FAIL m0_in_ready: got %b expected 0100", In_Ready); else passed++;
    step();
    total++; if (Mux_Output !== 8'hA5 || Out_Channel !== 3'd2 || Out_Valid !== 1'b1)
      $display("FAIL m0_word: got data %h ch %0d v %b expected A5 2 1", Mux_Output, Out_Channel, Out_Valid);
    else passed++;
    Selector = 3'd1; In_Valid = 4'b0100;
    #1;
    total++; if (In_Ready !== 4'b0000) $display("FAIL m0_sel_invalid: got %b expected 0000", In_Ready); else passed++;
    Selector = 3'd5; In_Valid = 4'b1111;
    #1;
    total++; if (In_Ready !== 4'b0000) $display("FAIL m0_out_of_range: got %b expected 0000", In_Ready); else passed++;
    step();
    total++; if (Out_Valid !== 1'b0 || Mux_Output !== 8'hA5 || Out_Channel !== 3'd2)
      $display("FAIL m0_drain_hold: got v %b data %h ch %0d expected 0 A5 2", Out_Valid, Mux_Output, Out_Channel);
    else passed++;
  endtask

  task automatic test_pointer_mode_switch();
    do_reset();
    Mode = 1'b0; Selector = 3'd2; In_Valid = 4'b1111; Out_Ready = 1'b1;
    step();
    Mode = 1'b1;
    #1;
    total++; if (In_Ready !== 4'b1000) $display("FAIL switch_pointer: got %b expected 1000", In_Ready); else passed++;
  endtask

  task automatic test_round_robin();
    logic [W-1:0] exp_w;
    do_reset();
    Mode = 1'b1; Out_Ready = 1'b1; In_Valid = 4'b1111;
    set_word(0, 8'h10); set_word(1, 8'h11); set_word(2, 8'h12); set_word(3, 8'h13);
    for (int i = 0; i < 8; i++) begin
      step();
      exp_w = 8'h10 + W'(i % CH);
      total++; if (Out_Channel !== SW'(i % CH) || Mux_Output !== exp_w || Out_Valid !== 1'b1)
        $display("FAIL rr_cycle%0d: got ch %0d data %h v %b expected ch %0d data %h v 1",
                 i, Out_Channel, Mux_Output, Out_Valid, i % CH, exp_w);
      else passed++;
    end
  endtask

  task automatic test_skip_idle();
    int exp_ch;
    do_reset();
    Mode = 1'b1; Out_Ready = 1'b1; In_Valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      exp_ch = (i % 2 == 0) ? 1 : 3;
      #1;
      total++; if (In_Ready !== 4'(1 << exp_ch))
        $display("FAIL skip_ready%0d: got %b expected %b", i, In_Ready, 4'(1 << exp_ch));
      else passed++;
      step();
      total++; if (Out_Channel !== SW'(exp_ch))
        $display("FAIL skip_chan%0d: got %0d expected %0d", i, Out_Channel, exp_ch);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    Mode = 1'b0; Selector = 3'd1; set_word(1, 8'h3C); In_Valid = 4'b0010; Out_Ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      In_Valid = (i % 2 == 0) ? 4'b1111 : 4'b0101;
      Selector = SW'(i % CH);
      Mode = (i % 2 == 1);
      set_word(i % CH, 8'hC0 + W'(i));
      #1;
      total++; if (In_Ready !== 4'b0000) $display("FAIL bp_ready%0d: got %b expected 0000", i, In_Ready); else passed++;
      step();
      total++; if (Mux_Output !== 8'h3C || Out_Valid !== 1'b1 || Out_Channel !== 3'd1)
        $display("FAIL bp_hold%0d: got data %h v %b ch %0d expected 3C 1 1", i, Mux_Output, Out_Valid, Out_Channel);
      else passed++;
    end
    Mode = 1'b0; Selector = 3'd3; set_word(3, 8'h5A); In_Valid = 4'b1000; Out_Ready = 1'b1;
    #1;
    total++; if (In_Ready !== 4'b1000) $display("FAIL bp_release_ready: got %b expected 1000", In_Ready); else passed++;
    step();
    total++; if (Mux_Output !== 8'h5A || Out_Channel !== 3'd3 || Out_Valid !== 1'b1)
      $display("FAIL bp_replace: got data %h ch %0d v %b expected 5A 3 1", Mux_Output, Out_Channel, Out_Valid);
    else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    Mode = 1'b0; Selector = 3'd2; set_word(2, 8'hFF); In_Valid = 4'b0100; Out_Ready = 1'b0;
    step();
    total++; if (Out_Valid !== 1'b1 || Mux_Output !== 8'hFF)
      $display("FAIL mid_full: got v %b data %h expected 1 FF", Out_Valid, Mux_Output);
    else passed++;
    reset = 1'b1; Out_Ready = 1'b1; In_Valid = 4'b1111;
    #1;
    total++; if (In_Ready !== 4'b0000) $display("FAIL mid_reset_ready: got %b expected 0000", In_Ready); else passed++;
    step();
    reset = 1'b0; Out_Ready = 1'b0;
    total++; if (Out_Valid !== 1'b0 || Mux_Output !== 8'h00 || Out_Channel !== 3'd0)
      $display("FAIL mid_cleared: got v %b data %h ch %0d expected 0 00 0", Out_Valid, Mux_Output, Out_Channel);
    else passed++;
    Mode = 1'b1; set_word(0, 8'h77); Out_Ready = 1'b1;
    #1;
    total++; if (In_Ready !== 4'b0001) $display("FAIL mid_restart_ready: got %b expected 0001", In_Ready); else passed++;
    step();
    total++; if (Out_Channel !== 3'd0 || Mux_Output !== 8'h77)
      $display("FAIL mid_restart_word: got ch %0d data %h expected 0 77", Out_Channel, Mux_Output);
    else passed++;
  endtask

  initial begin
    reset = 1'b1; Mode = 1'b0; Selector = '0; Data_In = '0; In_Valid = '0; Out_Ready = 1'b0;
    test_reset();
    test_mode0();
    test_pointer_mode_switch();
    test_round_robin();
    test_skip_idle();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
